// File: rtl/pwm_gen.sv
// pwm_gen: free-running PWM, duty = compare / 2^WIDTH, glitch-free period-aligned updates
module pwm_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] compare,
    output logic             pwm
);
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             pwm_q, pwm_d;

    // next state: wrapping counter, shadow load on the last count, compare against the active duty
    always_comb begin
        cnt_d  = cnt_q + WIDTH'(1);
        duty_d = (&cnt_q) ? compare : duty_q;
        pwm_d  = cnt_q < duty_q;
    end

    // state registers; active-low asynchronous clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm = pwm_q;
endmodule

// File: tb/tb_pwm_gen.sv
// tb_pwm_gen: scoreboard bench, expected high-cycle counts per period queued by stimulus
module tb_pwm_gen;
    localparam int NCH = 5;
    localparam int P   = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] cmp [NCH];
    logic       pw [NCH];
    int         cyc;
    int         exp_q [NCH][$];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        pwm_gen #(.WIDTH(8)) u_dut (
            .clk(clk),
            .rst(rst_n),
            .compare(cmp[g]),
            .pwm(pw[g])
        );
    end

    // bench cycle count: value k after the k-th rising edge since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic chk(input string name, input int ch, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s ch%0d: got %0d expected %0d (t=%0t)", name, ch, got, exp, $time);
        end
    endtask

    function automatic int at(input int p, input int i);
        return P * p + i + 1;
    endfunction

    task automatic wait_at(input int k);
        while (cyc != k) @(negedge clk);
    endtask

    // monitor: measure each period and compare against the scoreboard
    int hi [NCH];
    bit seen_lo [NCH];
    bit bad [NCH];
    always @(negedge clk) begin
        if (rst_n && cyc > 0) begin
            for (int c = 0; c < NCH; c++) begin
                if ((cyc - 1) % P == 0) begin
                    hi[c] = 0;
                    seen_lo[c] = 0;
                    bad[c] = 0;
                end
                if (pw[c]) begin
                    hi[c]++;
                    if (seen_lo[c]) bad[c] = 1;
                end else begin
                    seen_lo[c] = 1;
                end
                if ((cyc - 1) % P == P - 1) begin
                    if (exp_q[c].size() == 0) chk("scoreboard_underflow", c, 1, 0);
                    else chk("high_cycles", c, hi[c], exp_q[c].pop_front());
                    chk("contiguous", c, int'(bad[c]), 0);
                end
            end
        end
    end

    initial begin
        cmp[0] = 8'd192;
        cmp[1] = 8'd128;
        cmp[2] = 8'd64;
        cmp[3] = 8'd32;
        cmp[4] = 8'd0;
        for (int c = 0; c < 4; c++) begin
            exp_q[c].push_back(0);
            for (int p = 1; p < 8; p++) exp_q[c].push_back(int'(cmp[c]));
        end
        exp_q[4].push_back(0);
        exp_q[4].push_back(0);
        repeat (5) @(negedge clk);
        for (int c = 0; c < NCH; c++) chk("reset_pwm", c, int'(pw[c]), 0);
        chk("reset_cnt", 0, int'(g_ch[0].u_dut.cnt_q), 0);
        rst_n = 1'b1;
        wait_at(at(1, 50));
        cmp[4] = 8'd255;
        exp_q[4].push_back(255);
        wait_at(at(2, 10));
        cmp[4] = 8'd64;
        exp_q[4].push_back(64);
        wait_at(at(3, 99));
        cmp[4] = 8'd200;
        exp_q[4].push_back(200);
        wait_at(at(4, 254));
        cmp[4] = 8'd32;
        exp_q[4].push_back(32);
        wait_at(at(5, 255));
        cmp[4] = 8'd128;
        exp_q[4].push_back(32);
        exp_q[4].push_back(128);
        wait_at(at(8, 10));
        chk("mid_period_high", 0, int'(pw[0]), 1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int c = 0; c < NCH; c++) chk("async_reset_pwm", c, int'(pw[c]), 0);
        for (int c = 0; c < NCH; c++) chk("scoreboard_left", c, exp_q[c].size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
